// File: rtl/conv3x3_stream.sv
// Streaming 3x3 kernel filter: two line buffers feed a column window, a tap
// register stage, then a per-channel multiply/shift/saturate output stage.
module conv3x3_stream #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int CH    = 3,
  parameter int CW    = 3,
  parameter int KW    = 3,
  parameter int SW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                coef_we,
  input  logic [3:0]          coef_idx,
  input  logic [KW-1:0]       coef_data,
  input  logic [SW-1:0]       shift_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [CH*CW-1:0]    in_data,
  output logic                out_valid,
  output logic                out_sof,
  output logic                out_eol,
  output logic [CH*CW-1:0]    out_data,
  output logic                busy
);
  localparam int PW   = CH * CW;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = $clog2(IMG_H + 2);
  localparam int SUMW = CW + KW + 4;
  localparam logic [XW-1:0]   X_LAST  = XW'(IMG_W - 1);
  localparam logic [XW-1:0]   X_ONE   = XW'(1);
  localparam logic [YW-1:0]   Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0]   Y_FLUSH = YW'(IMG_H);
  localparam logic [YW-1:0]   Y_END   = YW'(IMG_H + 1);
  localparam logic [YW-1:0]   Y_ONE   = YW'(1);
  localparam logic [YW-1:0]   Y_TWO   = YW'(2);
  localparam logic [SUMW-1:0] PIX_MAX = SUMW'((1 << CW) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic logic [CW-1:0] shift_sat(input logic [SUMW-1:0] sum,
                                              input logic [SW-1:0]   sh);
    logic [SUMW-1:0] v;
    v = sum >> sh;
    return (v > PIX_MAX) ? {CW{1'b1}} : v[CW-1:0];
  endfunction

  state_t          state, state_nx;
  logic [XW-1:0]   x, sx;
  logic [YW-1:0]   y, sy;
  logic            accept, start, slot, last_in, flush_end;
  logic [PW-1:0]   pix;

  logic [KW-1:0]   kstage [9];
  logic [KW-1:0]   kact   [9];
  logic [SW-1:0]   shift_act;
  logic [1:0]      mode_act;

  logic [PW-1:0]   lb1 [IMG_W];
  logic [PW-1:0]   lb2 [IMG_W];
  logic [PW-1:0]   n_col [3];
  logic [PW-1:0]   c1 [3];
  logic [PW-1:0]   c2 [3];

  logic [PW-1:0]   tap_p0 [3][3];
  logic            vld_p0, sof_p0, eol_p0;
  logic [SUMW-1:0] acc_sum;
  logic [CW-1:0]   centre, px_res;
  logic [PW-1:0]   result;

  assign accept    = in_valid && in_ready;
  assign start     = (state == IDLE) && accept && in_sof;
  assign slot      = start || ((state == RUN) && accept) || (state == FLUSH);
  // The frame-opening pixel is slot (0,0); x/y already point past it afterwards.
  assign sx        = (state == IDLE) ? '0 : x;
  assign sy        = (state == IDLE) ? '0 : y;
  assign last_in   = (state == RUN) && accept && (x == X_LAST) && (y == Y_LAST);
  assign flush_end = (state == FLUSH) && (y == Y_END);
  assign pix       = (state == FLUSH) ? '0 : in_data;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = RUN;
      RUN:     if (last_in)   state_nx = FLUSH;
      FLUSH:   if (flush_end) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      in_ready  <= 1'b0;
      shift_act <= '0;
      mode_act  <= 2'd2;
      for (int i = 0; i < 9; i++) begin
        kstage[i] <= (i == 4) ? KW'(1) : '0;
        kact[i]   <= (i == 4) ? KW'(1) : '0;
      end
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FLUSH);
      if (slot) begin
        if (sx == X_LAST) begin
          x <= '0;
          y <= sy + Y_ONE;
        end else begin
          x <= sx + X_ONE;
          y <= sy;
        end
      end
      // Active copy reads the old staging value, so a coincident write lands next frame.
      if (start) begin
        kact      <= kstage;
        shift_act <= shift_in;
        mode_act  <= mode;
      end
      if (coef_we && (coef_idx <= 4'd8))
        kstage[coef_idx] <= coef_data;
    end
  end

  // Column entering the window; top/bottom rows clamp at the frame edges.
  always_comb begin
    n_col[0] = (sy == Y_ONE) ? lb1[sx] : lb2[sx];
    n_col[1] = lb1[sx];
    n_col[2] = (sy == Y_FLUSH) ? lb1[sx] : pix;
  end

  // Stage p0: line buffers, column window and clamped 3x3 taps.
  always_ff @(posedge clk) begin
    if (slot) begin
      lb2[sx] <= lb1[sx];
      lb1[sx] <= pix;
      for (int r = 0; r < 3; r++) begin
        c1[r]        <= c2[r];
        c2[r]        <= n_col[r];
        tap_p0[r][0] <= (sx == X_ONE) ? c2[r] : c1[r];
        tap_p0[r][1] <= c2[r];
        tap_p0[r][2] <= (sx == '0) ? c2[r] : n_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eol_p0 <= 1'b0;
    end else begin
      vld_p0 <= slot && ((sy >= Y_TWO) || ((sy == Y_ONE) && (sx != '0)));
      sof_p0 <= slot && (sy == Y_ONE) && (sx == X_ONE);
      eol_p0 <= slot && (sy >= Y_TWO) && (sx == '0);
    end
  end

  always_comb begin
    result  = '0;
    acc_sum = '0;
    centre  = '0;
    px_res  = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc_sum = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          acc_sum = acc_sum + SUMW'(tap_p0[r][c][ch*CW +: CW]) * SUMW'(kact[r*3+c]);
      centre = tap_p0[1][1][ch*CW +: CW];
      case (mode_act)
        2'd0:    px_res = shift_sat(acc_sum, shift_act);
        2'd1:    px_res = ~centre;
        default: px_res = centre;
      endcase
      result[ch*CW +: CW] = px_res;
    end
  end

  // Stage p1: registered output pixel and framing flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= vld_p0;
      out_sof   <= sof_p0;
      out_eol   <= eol_p0;
      if (vld_p0) out_data <= result;
    end
  end
endmodule
